// File: rtl/jedro_1_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp with optional prescaler and registered bus read port.
// Optional prescaler is built only when JEDRO_1_MTIMER_PRESCALER_EN is defined.
module jedro_1_mtimer #(
    parameter int DATA_WIDTH  = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    input  logic                  re_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  err_o,
    output logic                  timer_irq_o
);

    localparam logic [4:0] ADDR_MTIME_LO    = 5'h00;
    localparam logic [4:0] ADDR_MTIME_HI    = 5'h04;
    localparam logic [4:0] ADDR_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] ADDR_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] ADDR_CTRL        = 5'h10;

    logic [63:0]           mtime_reg, mtime_next;
    logic [63:0]           mtimecmp_reg, mtimecmp_next;
    logic [31:0]           shadow_reg, shadow_next;
    logic                  en_reg, en_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  rvalid_reg, rvalid_next;
    logic                  err_reg, err_next;
    logic                  irq_reg;

    logic                  addr_ok;
    logic                  wr_en;
    logic                  rd_en;
    logic                  tick;
    logic [PRESC_WIDTH-1:0] presc_val;
    logic [DATA_WIDTH-1:0] ctrl_rdata;
    logic [DATA_WIDTH-1:0] rd_mux;

    always_comb begin
        addr_ok = 1'b0;
        case (addr_i)
            ADDR_MTIME_LO, ADDR_MTIME_HI, ADDR_MTIMECMP_LO,
            ADDR_MTIMECMP_HI, ADDR_CTRL: addr_ok = 1'b1;
            default:                     addr_ok = 1'b0;
        endcase
    end

    // A simultaneous write wins; the read half of the access is dropped.
    assign wr_en = we_i && addr_ok;
    assign rd_en = re_i && !we_i && addr_ok;

`ifdef JEDRO_1_MTIMER_PRESCALER_EN
    logic [PRESC_WIDTH-1:0] presc_reg, presc_next;
    logic [PRESC_WIDTH-1:0] presc_cnt_reg, presc_cnt_next;

    assign tick      = en_reg && (presc_cnt_reg == presc_reg);
    assign presc_val = presc_reg;

    always_comb begin
        presc_next     = presc_reg;
        presc_cnt_next = presc_cnt_reg + 1'b1;
        if (wr_en && addr_i == ADDR_CTRL) begin
            presc_next     = wdata_i[PRESC_WIDTH+7:8];
            presc_cnt_next = '0;
        end else if (!en_reg || tick) begin
            presc_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_reg     <= '0;
            presc_cnt_reg <= '0;
        end else begin
            presc_reg     <= presc_next;
            presc_cnt_reg <= presc_cnt_next;
        end
    end
`else
    assign tick      = en_reg;
    assign presc_val = '0;
`endif

    // CTRL image: EN at bit 0, PRESC at [PRESC_WIDTH+7:8], all else zero.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_ctrl
            if (gi == 0) begin : g_en
                assign ctrl_rdata[gi] = en_reg;
            end else if (gi >= 8 && gi < 8 + PRESC_WIDTH) begin : g_presc
                assign ctrl_rdata[gi] = presc_val[gi-8];
            end else begin : g_zero
                assign ctrl_rdata[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            ADDR_MTIME_LO:    rd_mux = mtime_reg[31:0];
            ADDR_MTIME_HI:    rd_mux = shadow_reg;
            ADDR_MTIMECMP_LO: rd_mux = mtimecmp_reg[31:0];
            ADDR_MTIMECMP_HI: rd_mux = mtimecmp_reg[63:32];
            ADDR_CTRL:        rd_mux = ctrl_rdata;
            default:          rd_mux = '0;
        endcase
    end

    always_comb begin
        mtime_next    = mtime_reg;
        mtimecmp_next = mtimecmp_reg;
        shadow_next   = shadow_reg;
        en_next       = en_reg;
        if (wr_en && addr_i == ADDR_MTIME_LO) begin
            mtime_next[31:0] = wdata_i;
        end else if (wr_en && addr_i == ADDR_MTIME_HI) begin
            mtime_next[63:32] = wdata_i;
        end else if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end
        if (wr_en && addr_i == ADDR_MTIMECMP_LO) mtimecmp_next[31:0]  = wdata_i;
        if (wr_en && addr_i == ADDR_MTIMECMP_HI) mtimecmp_next[63:32] = wdata_i;
        if (wr_en && addr_i == ADDR_CTRL)        en_next              = wdata_i[0];
        // Latch the upper half on a low read so a later HI read is coherent.
        if (rd_en && addr_i == ADDR_MTIME_LO)    shadow_next          = mtime_reg[63:32];
        rdata_next  = rd_en ? rd_mux : '0;
        rvalid_next = re_i && !we_i;
        err_next    = (we_i || re_i) && !addr_ok;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
            shadow_reg   <= '0;
            en_reg       <= 1'b0;
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
            err_reg      <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            shadow_reg   <= shadow_next;
            en_reg       <= en_next;
            rdata_reg    <= rdata_next;
            rvalid_reg   <= rvalid_next;
            err_reg      <= err_next;
            irq_reg      <= (mtime_reg >= mtimecmp_reg);
        end
    end

    assign rdata_o     = rdata_reg;
    assign rvalid_o    = rvalid_reg;
    assign err_o       = err_reg;
    assign timer_irq_o = irq_reg;

endmodule

// File: tb/tb_jedro_1_mtimer.sv
// Self-checking bench for jedro_1_mtimer: vector table plus timing sequences, scoreboard on the read port.
module tb_jedro_1_mtimer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic        re_i = 1'b0;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        err_o;
    logic        timer_irq_o;

    jedro_1_mtimer #(.DATA_WIDTH(32), .PRESC_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .we_i        (we_i),
        .re_i        (re_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .err_o       (err_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef JEDRO_1_MTIMER_PRESCALER_EN
    localparam logic [31:0] CTRL_FF00_RD = 32'h0000_FF00;
    localparam logic [31:0] CTRL_0300_RD = 32'h0000_0300;
    localparam logic [31:0] MTIME_AFTER_40 = 32'd10;
`else
    localparam logic [31:0] CTRL_FF00_RD = 32'h0;
    localparam logic [31:0] CTRL_0300_RD = 32'h0;
    localparam logic [31:0] MTIME_AFTER_40 = 32'd41;
`endif

    typedef struct {
        logic        rv;
        logic        er;
        logic [31:0] rd;
        string       name;
    } exp_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        rv;
        logic        er;
        logic [31:0] rd;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tbl[24];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mkv(logic we, logic re, logic [4:0] a, logic [31:0] d,
                                 logic rv, logic er, logic [31:0] rd);
        vec_t v;
        v.we = we; v.re = re; v.addr = a; v.wdata = d;
        v.rv = rv; v.er = er; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic access(input logic we, input logic re, input logic [4:0] a, input logic [31:0] d,
                          input logic erv, input logic eer, input logic [31:0] erd, input string nm);
        exp_t e;
        @(negedge clk_i);
        we_i = we; re_i = re; addr_i = a; wdata_i = d;
        e.rv = erv; e.er = eer; e.rd = erd; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        we_i = 1'b0; re_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input string nm);
        access(1'b1, 1'b0, a, d, 1'b0, 1'b0, 32'h0, nm);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
        access(1'b0, 1'b1, a, 32'h0, 1'b1, 1'b0, exp, nm);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Scoreboard: each access expects its response 1 cycle later; otherwise the port must be quiet.
    always @(posedge clk_i) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (rvalid_o !== mon_e.rv || err_o !== mon_e.er || rdata_o !== mon_e.rd) begin
                miscompares++;
                $display("FAIL %s: got rvalid=%b err=%b rdata=%h expected rvalid=%b err=%b rdata=%h",
                         mon_e.name, rvalid_o, err_o, rdata_o, mon_e.rv, mon_e.er, mon_e.rd);
            end
        end else if (rvalid_o !== 1'b0 || err_o !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_port: got rvalid=%b err=%b expected 0 0", rvalid_o, err_o);
        end
    end

    initial begin
        tbl[0]  = mkv(0, 1, 5'h10, 32'h0,         1, 0, 32'h0);
        tbl[1]  = mkv(0, 1, 5'h08, 32'h0,         1, 0, 32'hFFFF_FFFF);
        tbl[2]  = mkv(0, 1, 5'h0C, 32'h0,         1, 0, 32'hFFFF_FFFF);
        tbl[3]  = mkv(0, 1, 5'h00, 32'h0,         1, 0, 32'h0);
        tbl[4]  = mkv(0, 1, 5'h04, 32'h0,         1, 0, 32'h0);
        tbl[5]  = mkv(1, 0, 5'h08, 32'h1234_5678, 0, 0, 32'h0);
        tbl[6]  = mkv(0, 1, 5'h08, 32'h0,         1, 0, 32'h1234_5678);
        tbl[7]  = mkv(0, 1, 5'h0C, 32'h0,         1, 0, 32'hFFFF_FFFF);
        tbl[8]  = mkv(1, 0, 5'h04, 32'hABCD_0001, 0, 0, 32'h0);
        tbl[9]  = mkv(1, 0, 5'h00, 32'h0000_0042, 0, 0, 32'h0);
        tbl[10] = mkv(0, 1, 5'h00, 32'h0,         1, 0, 32'h0000_0042);
        tbl[11] = mkv(0, 1, 5'h04, 32'h0,         1, 0, 32'hABCD_0001);
        tbl[12] = mkv(0, 1, 5'h14, 32'h0,         1, 1, 32'h0);
        tbl[13] = mkv(1, 0, 5'h14, 32'hDEAD_BEEF, 0, 1, 32'h0);
        tbl[14] = mkv(0, 1, 5'h02, 32'h0,         1, 1, 32'h0);
        tbl[15] = mkv(1, 0, 5'h09, 32'h0,         0, 1, 32'h0);
        tbl[16] = mkv(0, 1, 5'h08, 32'h0,         1, 0, 32'h1234_5678);
        tbl[17] = mkv(1, 1, 5'h0C, 32'h0000_0007, 0, 0, 32'h0);
        tbl[18] = mkv(0, 1, 5'h0C, 32'h0,         1, 0, 32'h0000_0007);
        tbl[19] = mkv(1, 0, 5'h10, 32'hFFFF_FF00, 0, 0, 32'h0);
        tbl[20] = mkv(0, 1, 5'h10, 32'h0,         1, 0, CTRL_FF00_RD);
        tbl[21] = mkv(1, 0, 5'h10, 32'h0,         0, 0, 32'h0);
        tbl[22] = mkv(0, 1, 5'h1C, 32'h0,         1, 1, 32'h0);
        tbl[23] = mkv(0, 1, 5'h00, 32'h0,         1, 0, 32'h0000_0042);

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_rdata", rdata_o, 0);
        chk("reset_rvalid", rvalid_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_irq", timer_irq_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 24; i++)
            access(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata,
                   tbl[i].rv, tbl[i].er, tbl[i].rd, $sformatf("vec%0d", i));
        @(negedge clk_i);
        chk("irq_after_table", timer_irq_o, 1);

        // Compare match: mtime counts 0..10, irq follows one cycle later.
        do_reset();
        wr(5'h08, 32'd10, "cmp_lo10");
        wr(5'h0C, 32'd0, "cmp_hi0");
        wr(5'h10, 32'h1, "ctrl_en");
        repeat (10) @(posedge clk_i);
        #1;
        chk("irq_at_mtime10", timer_irq_o, 0);
        @(posedge clk_i);
        #1;
        chk("irq_after_mtime10", timer_irq_o, 1);
        wr(5'h10, 32'h0, "ctrl_stop_a");
        rd(5'h00, 32'd12, "mtime_stop_a");
        repeat (3) @(posedge clk_i);
        #1;
        chk("irq_level_hold", timer_irq_o, 1);

        // Carry from low to high half, then full 64-bit wrap.
        wr(5'h04, 32'h0, "b_hi0");
        wr(5'h00, 32'hFFFF_FFFF, "b_lo_ones");
        wr(5'h10, 32'h1, "b_en");
        wr(5'h10, 32'h0, "b_stop");
        rd(5'h00, 32'h0, "carry_lo");
        rd(5'h04, 32'h1, "carry_hi");
        wr(5'h00, 32'hFFFF_FFFF, "w_lo_ones");
        wr(5'h04, 32'hFFFF_FFFF, "w_hi_ones");
        wr(5'h10, 32'h1, "w_en");
        wr(5'h10, 32'h0, "w_stop");
        rd(5'h00, 32'h0, "wrap_lo");
        rd(5'h04, 32'h0, "wrap_hi");

        // Shadowed high half: LO read just before the carry, HI read later.
        wr(5'h04, 32'h0, "c_hi0");
        wr(5'h00, 32'hFFFF_FFFE, "c_lo");
        wr(5'h10, 32'h1, "c_en");
        rd(5'h00, 32'hFFFF_FFFE, "shadow_lo");
        repeat (4) @(posedge clk_i);
        rd(5'h04, 32'h0, "shadow_hi");
        wr(5'h10, 32'h0, "c_stop");

        // Write beats tick in the same cycle.
        wr(5'h04, 32'h0, "d_hi0");
        wr(5'h00, 32'h0, "d_lo0");
        wr(5'h10, 32'h1, "d_en");
        wr(5'h00, 32'd5, "d_lo5");
        rd(5'h00, 32'd5, "write_over_tick");
        wr(5'h10, 32'h0, "d_stop");

        // Prescaler 3: one tick per 4 cycles (every cycle without the prescaler).
        wr(5'h00, 32'h0, "p_lo0");
        wr(5'h10, 32'h0000_0301, "p_ctrl");
        repeat (40) @(posedge clk_i);
        wr(5'h10, 32'h0, "p_stop");
        rd(5'h00, MTIME_AFTER_40, "presc_mtime");
        wr(5'h10, 32'h0000_0300, "p_ctrl_presc_only");
        rd(5'h10, CTRL_0300_RD, "presc_readback");

        // Reset during a read while irq is high.
        wr(5'h08, 32'h0, "e_cmp_lo0");
        wr(5'h0C, 32'h0, "e_cmp_hi0");
        repeat (2) @(posedge clk_i);
        #1;
        chk("irq_before_reset", timer_irq_o, 1);
        @(negedge clk_i);
        rst_i = 1'b1; re_i = 1'b1; addr_i = 5'h08;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; re_i = 1'b0;
        chk("rst_irq", timer_irq_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_err", err_o, 0);
        rd(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(5'h00, 32'h0, "rst_mtime_lo");
        rd(5'h10, 32'h0, "rst_ctrl");

        repeat (3) @(posedge clk_i);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jedro_1_mtimer.md
JEDRO_1_MTIMER -- requirements
Module: jedro_1_mtimer

Interface
REQ-001 Parameter: DATA_WIDTH, 32, register bus data width; only 32 supported.
REQ-002 Parameter: PRESC_WIDTH, 8, width of the CTRL.PRESC field.
REQ-003 Port: clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst_i  input  1  synchronous reset, active-high.
REQ-005 Port: addr_i  input  5  byte address: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL.
REQ-006 Port: wdata_i  input  DATA_WIDTH  write data.
REQ-007 Port: we_i  input  1  write strobe, one access per cycle.
REQ-008 Port: re_i  input  1  read strobe; if asserted together with we_i, the write is performed and the read is ignored.
REQ-009 Port: rdata_o  output  DATA_WIDTH  read data, registered.
REQ-010 Port: rvalid_o  output  1  read data valid, one cycle after re_i.
REQ-011 Port: err_o  output  1  one-cycle pulse, one cycle after an access to an unmapped address or to addr_i[1:0] != 0.
REQ-012 Port: timer_irq_o  output  1  machine timer interrupt level; drives the CSR block's timer_irq_i.

Function
REQ-013 mtime: 64-bit counter; mtimecmp: 64-bit register; CTRL[0] EN; CTRL[PRESC_WIDTH+7:8] PRESC; other CTRL bits read 0 and ignore writes.
REQ-014 Tick: with EN=1, a tick is generated on every cycle in which the prescaler counter equals PRESC; that cycle the prescaler counter returns to 0, otherwise it increments by 1.
REQ-015 PRESC=0 gives one tick per cycle; PRESC=N gives one tick every N+1 cycles.
REQ-016 Each tick increments mtime by 1; 0xFFFF_FFFF_FFFF_FFFF wraps to 0; carry from the low half into the high half occurs in the same cycle.
REQ-017 EN=0: mtime holds and the prescaler counter is held at 0.
REQ-018 Writing CTRL resets the prescaler counter to 0.
REQ-019 A write to MTIME_LO or MTIME_HI replaces only that half; the write takes priority over a tick in the same cycle, so no increment occurs that cycle.
REQ-020 Writes to MTIMECMP_LO or MTIMECMP_HI replace only that half.
REQ-021 Reads: rdata_o and rvalid_o are valid exactly one cycle after re_i; rdata_o is 0 whenever rvalid_o=0 or err_o=1.
REQ-022 Atomic 64-bit read: a read of MTIME_LO returns mtime[31:0] and captures mtime[63:32] into a shadow register; a read of MTIME_HI returns the shadow, not the live value.
REQ-023 Reads of MTIMECMP_* and CTRL return the current register value.
REQ-024 An unmapped or misaligned access: the write has no effect, err_o pulses, and rvalid_o pulses if re_i was asserted.
REQ-025 timer_irq_o is registered and equals (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on the previous cycle's values; one cycle latency; independent of EN.
REQ-026 timer_irq_o is a level, not a pulse; it clears one cycle after a write makes mtimecmp > mtime.

Reset
REQ-027 On rst_i=1, the following are set: mtime=0, shadow=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, EN=0, PRESC=0, prescaler counter=0, rdata_o=0, rvalid_o=0, err_o=0, timer_irq_o=0.
REQ-028 Reset asserted mid-access discards the access; no rvalid_o or err_o is produced in the cycle after reset.

Configuration
REQ-029 Macro JEDRO_1_MTIMER_PRESCALER_EN defined: prescaler behaves as in REQ-014 to REQ-018.
REQ-030 Macro JEDRO_1_MTIMER_PRESCALER_EN undefined: no prescaler logic is built; a tick occurs on every cycle with EN=1; the CTRL.PRESC field reads 0 and ignores writes.

Verification
REQ-031 Write MTIMECMP_LO=10, MTIMECMP_HI=0, then CTRL=0x1 -> mtime reaches 10 in 10 cycles; timer_irq_o rises 1 cycle later and stays high.
REQ-032 With PRESCALER_EN, write CTRL=0x0301 -> mtime increments once every 4 cycles; after 40 cycles mtime=10.
REQ-033 Set mtime=0x0000_0000_FFFF_FFFF, EN=1, PRESC=0 -> next cycle mtime=0x0000_0001_0000_0000; then set mtime=all-ones -> wraps to 0 next cycle.
REQ-034 Set mtime=0x0000_0000_FFFF_FFFE, EN=1; read LO the cycle before the carry, then read HI 5 cycles later -> rdata_o=0xFFFF_FFFE then 0x0000_0000 (shadow).
REQ-035 Write MTIME_LO=5 in a tick cycle -> mtime[31:0]=5 next cycle, not 6; access addr 0x14 -> err_o=1, rdata_o=0, no state change.
REQ-036 Assert rst_i for 1 cycle while timer_irq_o=1 and a read is pending -> next cycle timer_irq_o=0, rvalid_o=0, mtimecmp=all-ones.
